// File: rtl/hps_chan_mbox.sv
// rtl/hps_chan_mbox.sv - multi-channel byte mailbox between the HPS command bus and the core
// Each channel has a to-core and a from-core FIFO; three command codes give STATUS, WRITE and READ.
module hps_chan_mbox #(
  parameter int          CHANNELS = 2,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] CMD_BASE = 16'h0060
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  io_enable,
  input  logic                  io_strobe,
  input  logic [15:0]           io_din,
  output logic [15:0]           io_dout,
  output logic [8*CHANNELS-1:0] out_data,
  output logic [CHANNELS-1:0]   out_valid,
  input  logic [CHANNELS-1:0]   out_ready,
  input  logic [8*CHANNELS-1:0] in_data,
  input  logic [CHANNELS-1:0]   in_valid,
  output logic [CHANNELS-1:0]   in_ready
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LVL_ONE  = 1;
  localparam logic [AW-1:0]  PTR_ONE  = 1;

  logic [9:0]                     word_cnt;
  logic [15:0]                    cmd;
  logic [2:0]                     ch;
  logic                           bad;
  logic [CHANNELS-1:0]            ovf;

  logic                           is_status, is_write, is_read;
  logic                           strobe_w, wr_word, rd_word, ovf_clr, idx_bad;
  logic [15:0]                    dout_next;
  logic [CHANNELS-1:0]            tx_full_v, rx_ne_v, tx_push, rx_pop, ovf_set;
  logic [CHANNELS-1:0][AW:0]      rx_lvl_p;
  logic [CHANNELS-1:0][7:0]       rx_head_p;
  logic [AW:0]                    din_lvl;
  logic [7:0]                     ch_head;
  logic                           ch_rx_ne;

  assign is_status = (cmd == CMD_BASE);
  assign is_write  = (cmd == CMD_BASE + 16'd1);
  assign is_read   = (cmd == CMD_BASE + 16'd2);
  assign idx_bad   = ({1'b0, io_din[2:0]} >= 4'(CHANNELS));
  assign strobe_w  = io_enable & io_strobe & (word_cnt != 10'd0);
  assign wr_word   = strobe_w & is_write & (word_cnt >= 10'd2) & ~bad;
  assign rd_word   = strobe_w & is_read & (word_cnt >= 10'd2) & ~bad;
  assign ovf_clr   = strobe_w & is_status & (word_cnt == 10'd2);

  always_comb begin
    din_lvl  = '0;
    ch_head  = '0;
    ch_rx_ne = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (io_din[2:0] == 3'(c)) din_lvl = rx_lvl_p[c];
      if (ch == 3'(c)) begin
        ch_head  = rx_head_p[c];
        ch_rx_ne = rx_ne_v[c];
      end
    end
  end

  // Reply word for the current strobe; only loaded when a non-command word is strobed.
  always_comb begin
    dout_next = '0;
    if (is_status && word_cnt == 10'd1)
      dout_next = {8'(tx_full_v), 8'(rx_ne_v)};
    else if (is_status && word_cnt == 10'd2)
      dout_next = {8'h00, 8'(ovf)};
    else if (is_read && word_cnt == 10'd1 && !idx_bad)
      dout_next = 16'(din_lvl);
    else if (rd_word && ch_rx_ne)
      dout_next = {1'b1, 7'b0, ch_head};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      cmd      <= '0;
      ch       <= '0;
      bad      <= 1'b0;
      io_dout  <= '0;
      ovf      <= '0;
    end else begin
      // A refused push in the clearing cycle keeps its flag set.
      ovf <= (ovf & ~{CHANNELS{ovf_clr}}) | ovf_set;
      if (!io_enable) begin
        word_cnt <= '0;
        cmd      <= '0;
        ch       <= '0;
        bad      <= 1'b0;
        io_dout  <= '0;
      end else if (io_strobe) begin
        if (word_cnt != 10'h3FF) word_cnt <= word_cnt + 10'd1;
        if (word_cnt == 10'd0) begin
          cmd     <= io_din;
          bad     <= 1'b0;
          io_dout <= '0;
        end else begin
          io_dout <= dout_next;
          if (word_cnt == 10'd1 && (is_write || is_read)) begin
            ch  <= io_din[2:0];
            bad <= idx_bad;
          end
        end
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [AW:0]   tx_lvl, rx_lvl;
    logic          tx_pop, rx_push;

    assign tx_pop             = out_valid[c] & out_ready[c];
    assign rx_push            = in_valid[c] & in_ready[c];
    assign out_valid[c]       = (tx_lvl != '0);
    assign out_data[8*c +: 8] = tx_mem[tx_rp];
    assign in_ready[c]        = (rx_lvl != FULL_LVL);
    assign tx_full_v[c]       = (tx_lvl == FULL_LVL);
    assign rx_ne_v[c]         = (rx_lvl != '0);
    assign rx_lvl_p[c]        = rx_lvl;
    assign rx_head_p[c]       = rx_mem[rx_rp];
    // Full is judged before any same-cycle pop, so a full FIFO refuses the byte.
    assign tx_push[c]         = wr_word & (ch == 3'(c)) & ~tx_full_v[c];
    assign ovf_set[c]         = wr_word & (ch == 3'(c)) & tx_full_v[c];
    assign rx_pop[c]          = rd_word & (ch == 3'(c)) & rx_ne_v[c];

    always_ff @(posedge clk_sys) begin
      if (tx_push[c]) tx_mem[tx_wp] <= io_din[7:0];
      if (rx_push)    rx_mem[rx_wp] <= in_data[8*c +: 8];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_lvl <= '0;
        rx_wp  <= '0;
        rx_rp  <= '0;
        rx_lvl <= '0;
      end else begin
        if (tx_push[c]) tx_wp <= tx_wp + PTR_ONE;
        if (tx_pop)     tx_rp <= tx_rp + PTR_ONE;
        case ({tx_push[c], tx_pop})
          2'b10:   tx_lvl <= tx_lvl + LVL_ONE;
          2'b01:   tx_lvl <= tx_lvl - LVL_ONE;
          default: ;
        endcase
        if (rx_push)   rx_wp <= rx_wp + PTR_ONE;
        if (rx_pop[c]) rx_rp <= rx_rp + PTR_ONE;
        case ({rx_push, rx_pop[c]})
          2'b10:   rx_lvl <= rx_lvl + LVL_ONE;
          2'b01:   rx_lvl <= rx_lvl - LVL_ONE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hps_chan_mbox.sv
// tb/tb_hps_chan_mbox.sv - self-checking bench for hps_chan_mbox
// Table-driven frames plus scoreboarded hand sequences on a DEPTH=16 and a DEPTH=4 instance.
module tb_hps_chan_mbox;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        io_enable, io_strobe;
  logic [15:0] io_din, io_dout;
  logic [15:0] out_data, in_data;
  logic [1:0]  out_valid, out_ready, in_valid, in_ready;

  logic        w_io_enable, w_io_strobe;
  logic [15:0] w_io_din, w_io_dout;
  logic [15:0] w_out_data, w_in_data;
  logic [1:0]  w_out_valid, w_out_ready, w_in_valid, w_in_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_tx [2][$];
  logic [7:0]  exp_rx [2][$];
  logic [15:0] exp_q [$];
  logic [1:0]  ovf_m;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] w [4];
    logic [15:0] r [4];
  } frame_t;
  frame_t tbl [7];

  always #5 clk_sys = ~clk_sys;

  hps_chan_mbox #(.CHANNELS(2), .DEPTH(16), .CMD_BASE(16'h0060)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .io_enable(io_enable), .io_strobe(io_strobe), .io_din(io_din), .io_dout(io_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  hps_chan_mbox #(.CHANNELS(2), .DEPTH(4), .CMD_BASE(16'h0060)) dut4 (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .io_enable(w_io_enable), .io_strobe(w_io_strobe), .io_din(w_io_din), .io_dout(w_io_dout),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string name, input int n,
                         input logic [15:0] w0, w1, w2, w3,
                         input logic [15:0] r0, r1, r2, r3);
    tbl[i].name = name;
    tbl[i].n    = n;
    tbl[i].w[0] = w0; tbl[i].w[1] = w1; tbl[i].w[2] = w2; tbl[i].w[3] = w3;
    tbl[i].r[0] = r0; tbl[i].r[1] = r1; tbl[i].r[2] = r2; tbl[i].r[3] = r3;
  endtask

  // Reply to a strobed word is checked right after the capturing edge.
  task automatic send_word(input bit which, input string name, input logic [15:0] w,
                           input logic [15:0] exp);
    exp_q.push_back(exp);
    @(posedge clk_sys); #1;
    if (which) begin w_io_din = w; w_io_strobe = 1'b1; end
    else       begin io_din = w;   io_strobe = 1'b1;   end
    @(posedge clk_sys); #1;
    if (which) begin w_io_strobe = 1'b0; chk(name, 32'(w_io_dout), 32'(exp_q.pop_front())); end
    else       begin io_strobe = 1'b0;   chk(name, 32'(io_dout), 32'(exp_q.pop_front())); end
  endtask

  task automatic frame_start(input bit which);
    @(posedge clk_sys); #1;
    if (which) w_io_enable = 1'b1; else io_enable = 1'b1;
  endtask

  task automatic frame_end(input bit which);
    @(posedge clk_sys); #1;
    if (which) w_io_enable = 1'b0; else io_enable = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic write_frame(input int c, input int n, input logic [7:0] base, input logic [7:0] inc);
    logic [7:0] b;
    frame_start(0);
    send_word(0, "wr_cmd", 16'h0061, 16'h0000);
    send_word(0, "wr_idx", 16'(c), 16'h0000);
    b = base;
    for (int k = 0; k < n; k++) begin
      if (c < 2) begin
        if (exp_tx[c].size() < 16) exp_tx[c].push_back(b);
        else ovf_m[c] = 1'b1;
      end
      send_word(0, "wr_data", {8'h00, b}, 16'h0000);
      b = b + inc;
    end
    frame_end(0);
  endtask

  task automatic read_frame(input int c, input int n);
    logic [15:0] e;
    frame_start(0);
    send_word(0, "rd_cmd", 16'h0062, 16'h0000);
    e = (c < 2) ? 16'(exp_rx[c].size()) : 16'h0000;
    send_word(0, "rd_level", 16'(c), e);
    for (int k = 0; k < n; k++) begin
      if (c < 2 && exp_rx[c].size() > 0) e = {8'h80, exp_rx[c].pop_front()};
      else e = 16'h0000;
      send_word(0, "rd_data", 16'h0000, e);
    end
    frame_end(0);
  endtask

  task automatic status_check();
    logic [15:0] w1, w2;
    w1 = {6'b0, exp_tx[1].size() == 16, exp_tx[0].size() == 16,
          6'b0, exp_rx[1].size() != 0, exp_rx[0].size() != 0};
    w2 = {14'b0, ovf_m};
    frame_start(0);
    send_word(0, "st_cmd", 16'h0060, 16'h0000);
    send_word(0, "st_masks", 16'h0000, w1);
    send_word(0, "st_ovf", 16'h0000, w2);
    ovf_m = 2'b00;
    frame_end(0);
  endtask

  task automatic core_push(input int c, input logic [7:0] b);
    @(posedge clk_sys); #1;
    in_data[8*c +: 8] = b;
    in_valid[c] = 1'b1;
    exp_rx[c].push_back(b);
    @(posedge clk_sys); #1;
    in_valid[c] = 1'b0;
  endtask

  // Scoreboard for the to-core side: every accepted byte must match the model head.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      for (int c = 0; c < 2; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          if (exp_tx[c].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_pop ch%0d: got %h want no byte", c, out_data[8*c +: 8]);
          end else begin
            chk($sformatf("out_data ch%0d", c), 32'(out_data[8*c +: 8]), 32'(exp_tx[c].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] wq [$];
    logic       w_ovf, push_ok;
    logic [7:0] wb;

    reset_n = 1'b0;
    io_enable = 0; io_strobe = 0; io_din = 0; out_ready = 0; in_data = 0; in_valid = 0;
    w_io_enable = 0; w_io_strobe = 0; w_io_din = 0; w_out_ready = 0; w_in_data = 0; w_in_valid = 0;
    ovf_m = 2'b00;

    set_vec(0, "tbl_status_rst", 3, 16'h0060, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    set_vec(1, "tbl_unknown",    3, 16'h0001, 16'h0000, 16'h0005, 0, 0, 0, 0, 0);
    set_vec(2, "tbl_read_empty", 4, 16'h0062, 16'h0001, 16'h0000, 16'h0000, 0, 0, 0, 0);
    set_vec(3, "tbl_read_badch", 4, 16'h0062, 16'h0005, 16'h0000, 16'h0000, 0, 0, 0, 0);
    set_vec(4, "tbl_write_badch",4, 16'h0061, 16'h0007, 16'h00AB, 16'h00CD, 0, 0, 0, 0);
    set_vec(5, "tbl_cmd_above",  3, 16'h0063, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    set_vec(6, "tbl_status_2",   3, 16'h0060, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    @(negedge clk_sys);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst in_ready", 32'(in_ready), 32'h3);
    chk("rst io_dout", 32'(io_dout), 32'h0);
    chk("rst w_in_ready", 32'(w_in_ready), 32'h3);

    for (int i = 0; i < 7; i++) begin
      frame_start(0);
      for (int k = 0; k < tbl[i].n; k++)
        send_word(0, tbl[i].name, tbl[i].w[k], tbl[i].r[k]);
      frame_end(0);
    end
    @(negedge clk_sys);
    chk("no push from bad frames", 32'(out_valid), 32'h0);

    out_ready = 2'b10;
    write_frame(1, 3, 8'h11, 8'h11);
    repeat (4) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("ch1 drained", 32'(out_valid), 32'h0);

    out_ready = 2'b00;
    write_frame(0, 18, 8'h01, 8'h01);
    @(negedge clk_sys);
    chk("ch0 holds bytes", 32'(out_valid), 32'h1);
    status_check();
    status_check();
    @(posedge clk_sys); #1 out_ready = 2'b01;
    repeat (25) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("ch0 drained", 32'(out_valid), 32'h0);
    chk("ch0 model empty", 32'(exp_tx[0].size()), 32'h0);

    core_push(1, 8'hA5);
    core_push(1, 8'h5A);
    read_frame(1, 4);
    read_frame(1, 0);
    status_check();

    // Wrap test on DEPTH=4: strobe a byte every other cycle while the core pops in a fixed pattern.
    frame_start(1);
    send_word(1, "w_cmd", 16'h0061, 16'h0000);
    send_word(1, "w_idx", 16'h0000, 16'h0000);
    w_ovf = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_sys); #1;
      wb = 8'(8'h40 + i);
      w_io_strobe = (i < 40) && (i % 2 == 0);
      w_io_din = {8'h00, wb};
      w_out_ready[0] = (i >= 10) && (i % 3 != 0);
      @(negedge clk_sys);
      chk($sformatf("wrap valid %0d", i), 32'(w_out_valid[0]), 32'(wq.size() != 0));
      if (w_out_valid[0] && w_out_ready[0] && wq.size() != 0)
        chk($sformatf("wrap data %0d", i), 32'(w_out_data[7:0]), 32'(wq[0]));
      push_ok = w_io_strobe && (wq.size() < 4);
      if (w_io_strobe && !push_ok) w_ovf = 1'b1;
      if (w_out_ready[0] && wq.size() != 0) void'(wq.pop_front());
      if (push_ok) wq.push_back(wb);
    end
    @(posedge clk_sys); #1 w_io_strobe = 1'b0; w_out_ready = 2'b00;
    frame_end(1);
    frame_start(1);
    send_word(1, "w_st_cmd", 16'h0060, 16'h0000);
    send_word(1, "w_st_masks", 16'h0000, 16'h0000);
    send_word(1, "w_st_ovf", 16'h0000, {15'b0, w_ovf});
    frame_end(1);

    frame_start(0);
    send_word(0, "abort_cmd", 16'h0061, 16'h0000);
    send_word(0, "abort_idx", 16'h0000, 16'h0000);
    frame_end(0);
    frame_start(0);
    send_word(0, "unk_cmd", 16'h0001, 16'h0000);
    send_word(0, "unk_w1", 16'h0000, 16'h0000);
    send_word(0, "unk_w2", 16'h00AB, 16'h0000);
    frame_end(0);
    @(negedge clk_sys);
    chk("no push after abort", 32'(out_valid), 32'h0);

    out_ready = 2'b00;
    core_push(0, 8'h77);
    write_frame(1, 2, 8'hC0, 8'h01);
    frame_start(0);
    send_word(0, "mid_rd_cmd", 16'h0062, 16'h0000);
    send_word(0, "mid_rd_level", 16'h0000, 16'h0001);
    @(posedge clk_sys); #1;
    reset_n = 1'b0;
    io_enable = 1'b0;
    exp_tx[0].delete(); exp_tx[1].delete(); exp_rx[0].delete(); exp_rx[1].delete();
    ovf_m = 2'b00;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    @(negedge clk_sys);
    chk("midrst out_valid", 32'(out_valid), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h3);
    chk("midrst io_dout", 32'(io_dout), 32'h0);
    read_frame(0, 1);
    status_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
